// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a one-word holding register.
//
// Serializes WIDTH-bit words LSB first, optionally followed by one even-parity
// bit. A pending word in the holding register starts in the cycle right after
// the previous frame's last bit, so back-to-back frames have no gap.
//
// Parameters:
//   WIDTH      data word width in bits (2..16)
//   PARITY_EN  1 appends an even-parity bit after the data bits
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   din          parallel word to serialize
//   din_valid    din holds a valid word
//   din_ready    a word can be accepted this cycle (holding register empty)
//   sout         serial data, LSB first
//   sout_valid   sout carries a frame bit this cycle
//   frame_start  sout carries bit 0 of a word this cycle
//   busy         shifter active or holding register occupied
module piso_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             par_q, par_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;

  logic accept;
  logic data_done;
  logic last_bit;

  assign accept    = din_valid & ~hold_full_q;
  assign data_done = (state_q == StData) && (cnt_q == LastCnt);
  // Cycle in which the shifter drives the final bit of the current frame.
  assign last_bit  = (data_done && (PARITY_EN == 0)) || (state_q == StParity);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      sout_q      <= 1'b0;
      valid_q     <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      sout_q      <= sout_d;
      valid_q     <= valid_d;
      fs_q        <= fs_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StData;
          shift_d = din;
          par_d   = ^din;
          cnt_d   = '0;
        end
      end
      StData: begin
        if (!data_done) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CntW'(1);
        end else if (PARITY_EN != 0) begin
          state_d = StParity;
        end
      end
      StParity: ;
      default: state_d = StIdle;
    endcase

    // End of frame: the held word has priority over a fresh one so order is kept.
    if (last_bit) begin
      if (hold_full_q) begin
        state_d     = StData;
        shift_d     = hold_q;
        par_d       = ^hold_q;
        cnt_d       = '0;
        hold_full_d = 1'b0;
      end else if (accept) begin
        state_d = StData;
        shift_d = din;
        par_d   = ^din;
        cnt_d   = '0;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end

    // A word that cannot go straight into the shifter waits in the holding register.
    if (accept && (state_q != StIdle) && (!last_bit || hold_full_q)) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  // Registered outputs, computed from the next state
  always_comb begin
    sout_d  = 1'b0;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    case (state_d)
      StData: begin
        sout_d  = shift_d[0];
        valid_d = 1'b1;
        fs_d    = (cnt_d == '0);
      end
      StParity: begin
        sout_d  = par_d;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign din_ready   = ~hold_full_q;
  assign sout        = sout_q;
  assign sout_valid  = valid_q;
  assign frame_start = fs_q;
  assign busy        = (state_q != StIdle) || hold_full_q;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx.
// u_dut runs WIDTH=4 without parity, u_par runs WIDTH=4 with parity.
// Outputs are sampled 1 time unit after the rising edge: the value seen after
// edge k+i is what the DUT drives during the cycle after that edge.
module tb_piso_tx;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready, sout, sout_valid, frame_start, busy;
  logic [3:0] pdin;
  logic       pdin_valid;
  logic       pdin_ready, psout, psout_valid, pframe_start, pbusy;

  int checks;
  int errors;

  piso_tx #(.WIDTH(4), .PARITY_EN(0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_start(frame_start),
    .busy       (busy)
  );

  piso_tx #(.WIDTH(4), .PARITY_EN(1)) u_par (
    .clk        (clk),
    .rst        (rst),
    .din        (pdin),
    .din_valid  (pdin_valid),
    .din_ready  (pdin_ready),
    .sout       (psout),
    .sout_valid (psout_valid),
    .frame_start(pframe_start),
    .busy       (pbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    din       = 4'b1111;
    din_valid = 1'b1;
    #2;
    repeat (3) begin
      checks++;
      if (din_ready !== 1'b1) begin
        errors++; $display("FAIL reset_ready: got %b want 1", din_ready);
      end
      checks++;
      if ({sout, sout_valid, frame_start, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs: got %b want 0000", {sout, sout_valid, frame_start, busy});
      end
      step();
    end
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_capture: busy got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    logic [3:0] w;
    w         = 4'b1011;
    din       = w;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({sout, sout_valid, frame_start} !== {w[i], 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL single_bit%0d: sout/valid/fs got %b want %b", i,
                 {sout, sout_valid, frame_start}, {w[i], 1'b1, (i == 0)});
      end
      step();
    end
    checks++;
    if ({sout, sout_valid, frame_start, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: got %b want 0000", {sout, sout_valid, frame_start, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    seq       = 8'b1000_0001;
    din       = 4'b0001;
    din_valid = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({sout, sout_valid, frame_start} !== {seq[c], 1'b1, (c == 0 || c == 4)}) begin
        errors++;
        $display("FAIL b2b_cycle%0d: sout/valid/fs got %b want %b", c,
                 {sout, sout_valid, frame_start}, {seq[c], 1'b1, (c == 0 || c == 4)});
      end
      if (c == 0) din = 4'b1000;
      if (c == 1) din_valid = 1'b0;
      step();
    end
    checks++;
    if ({sout_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: valid/busy got %b want 00", {sout_valid, busy});
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] seq;
    logic        exp_rdy;
    seq       = {4'b0011, 4'b1001, 4'b0110};
    din       = 4'b0110;
    din_valid = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      exp_rdy = !((c >= 1 && c <= 3) || (c >= 5 && c <= 7));
      checks++;
      if (din_ready !== exp_rdy) begin
        errors++; $display("FAIL bp_ready%0d: got %b want %b", c, din_ready, exp_rdy);
      end
      checks++;
      if ({sout, sout_valid, frame_start} !== {seq[c], 1'b1, (c % 4 == 0)}) begin
        errors++;
        $display("FAIL bp_cycle%0d: sout/valid/fs got %b want %b", c,
                 {sout, sout_valid, frame_start}, {seq[c], 1'b1, (c % 4 == 0)});
      end
      if (c == 0) din = 4'b1001;
      if (c == 1) din = 4'b0011;
      if (c == 5) din_valid = 1'b0;
      step();
    end
    checks++;
    if ({sout_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL bp_idle: valid/busy got %b want 00", {sout_valid, busy});
    end
  endtask

  task automatic test_parity();
    // 0111 -> 1,1,1,0,p=1 ; 0001 -> 1,0,0,0,p=1
    logic [9:0] seq;
    seq        = {1'b1, 4'b0001, 1'b1, 4'b0111};
    pdin       = 4'b0111;
    pdin_valid = 1'b1;
    step();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({psout, psout_valid, pframe_start} !== {seq[c], 1'b1, (c == 0 || c == 5)}) begin
        errors++;
        $display("FAIL parity_cycle%0d: sout/valid/fs got %b want %b", c,
                 {psout, psout_valid, pframe_start}, {seq[c], 1'b1, (c == 0 || c == 5)});
      end
      if (c == 0) pdin = 4'b0001;
      if (c == 1) pdin_valid = 1'b0;
      step();
    end
    checks++;
    if ({psout_valid, pbusy} !== 2'b00) begin
      errors++; $display("FAIL parity_idle: valid/busy got %b want 00", {psout_valid, pbusy});
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] w;
    din       = 4'b1111;
    din_valid = 1'b1;
    step();
    din = 4'b1100;  // parked in the holding register, must be discarded
    step();
    din_valid = 1'b0;
    checks++;
    if ({sout, sout_valid, busy} !== 3'b111) begin
      errors++; $display("FAIL midrst_pre: sout/valid/busy got %b want 111", {sout, sout_valid, busy});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({sout, sout_valid, frame_start, busy, din_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL midrst_async: sout/valid/fs/busy/ready got %b want 00001",
               {sout, sout_valid, frame_start, busy, din_ready});
    end
    @(negedge clk);
    rst       = 1'b1;
    w         = 4'b0101;
    din       = w;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({sout, sout_valid, frame_start} !== {w[i], 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL midrst_bit%0d: sout/valid/fs got %b want %b", i,
                 {sout, sout_valid, frame_start}, {w[i], 1'b1, (i == 0)});
      end
      step();
    end
    checks++;
    if ({sout_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL midrst_idle: valid/busy got %b want 00", {sout_valid, busy});
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    pdin       = 4'b0000;
    pdin_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_parity();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
